dcache_req_arbiter: RTL and testbench

Shares one `data_cache` request port between `NUM_REQ` requesters, such as per-core memory-access stages, a debug port or a DMA engine. It grants one load or store at a time in round-robin order, forwards the winner's request fields to the cache, and routes completion and load data back to the winner. It sits between the requesters' cache-request signals and the single `data_cache` instance. The requester's stall logic consumes its per-requester busy and done outputs.

---
 rtl/multicore_pkg.sv | 31 +++
 rtl/dcache_req_arbiter_rr_pick.sv | 49 ++++
 rtl/dcache_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the multicore memory subsystem: data width, load/store
// operation encodings and the data-cache request arbiter state encoding.
package multicore_pkg;

  localparam int unsigned DATA_SIZE = 32;

  typedef enum logic [2:0] {
    LDOP_LB,
    LDOP_LH,
    LDOP_LW,
    LDOP_LBU,
    LDOP_LHU
  } t_ldop;

  typedef enum logic [1:0] {
    SOP_SB,
    SOP_SH,
    SOP_SW
  } t_sop;

  // Word-sized access is the idle/default operation on the cache port.
  localparam t_ldop LDOP_DEFAULT = LDOP_LW;
  localparam t_sop  SOP_DEFAULT  = SOP_SW;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } t_dcarb_state;

endpackage

// File: rtl/dcache_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans the request vector
// starting at start_ptr (wrapping at NUM_REQ, which need not be a power of
// two) and returns the first requester as one-hot and binary index.
// Build option: DCACHE_ARB_FIXED_PRIO_EN forces the scan to start at 0
// (fixed priority, lowest index wins).
module rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] base;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  assign base = start_ptr;
`endif

  int unsigned      k;
  logic [IDX_W-1:0] k_idx;
  logic             found;

  // First requester at or after base, wrapping modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(base) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      k_idx = k[IDX_W-1:0];
      if (!found && req[k_idx]) begin
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: shares one data_cache request port between NUM_REQ
// requesters, one outstanding transaction at a time (IDLE -> ISSUE -> WAIT).
// Build option: DCACHE_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of round-robin; the rotating pointer is then absent.
module dcache_req_arbiter
  import multicore_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_SIZE = 32
) (
  input  logic                                i_aclk,
  input  logic                                i_reset,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ-1:0]                  i_req_write,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   i_addr,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]   i_store_data,
  input  t_sop [NUM_REQ-1:0]                  i_sop,
  input  t_ldop [NUM_REQ-1:0]                 i_ldop,
  output logic [NUM_REQ-1:0]                  o_gnt,
  output logic [NUM_REQ-1:0]                  o_busy,
  output logic [NUM_REQ-1:0]                  o_done,
  output logic [DATA_SIZE-1:0]                o_data,
  output logic                                o_req,
  output logic                                o_req_write,
  output logic [ADDR_SIZE-1:0]                o_addr,
  output logic [DATA_SIZE-1:0]                o_store_data,
  output t_sop                                o_sop,
  output t_ldop                               o_ldop,
  input  logic                                i_req_ready,
  input  logic                                i_data_valid,
  input  logic [DATA_SIZE-1:0]                i_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  t_dcarb_state         state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 write_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] sdata_q;
  t_sop                 sop_q;
  t_ldop                ldop_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     start_ptr;
  logic                 capture;
  logic                 complete;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  logic [IDX_W-1:0]     win_q;
  logic [IDX_W-1:0]     rr_ptr_q;

  assign start_ptr = rr_ptr_q;

  // Remember the winner and rotate the search start past it on completion.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      win_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (capture) begin
        win_q <= pick_idx;
      end
      if (complete) begin
        rr_ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req       (i_req),
    .start_ptr (start_ptr),
    .gnt       (pick_gnt),
    .idx       (pick_idx)
  );

  // Next-state and cache/requester handshake outputs.
  always_comb begin
    state_d  = state_q;
    o_req    = 1'b0;
    o_done   = '0;
    o_data   = '0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|i_req) begin
          capture = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        o_req = 1'b1;
        if (i_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (i_data_valid) begin
          o_done   = gnt_q;
          o_data   = i_data;
          complete = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant is held from the pick until the completion pulse.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      gnt_q <= '0;
    end else if (capture) begin
      gnt_q <= pick_gnt;
    end else if (complete) begin
      gnt_q <= '0;
    end
  end

  // Winner's request fields are sampled once, in IDLE, and held for the cache.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      sop_q   <= SOP_DEFAULT;
      ldop_q  <= LDOP_DEFAULT;
    end else if (capture) begin
      write_q <= i_req_write[pick_idx];
      addr_q  <= i_addr[pick_idx];
      sdata_q <= i_store_data[pick_idx];
      sop_q   <= i_sop[pick_idx];
      ldop_q  <= i_ldop[pick_idx];
    end
  end

  assign o_gnt        = gnt_q;
  assign o_busy       = i_req & ~o_done;
  assign o_req_write  = write_q;
  assign o_addr       = addr_q;
  assign o_store_data = sdata_q;
  assign o_sop        = sop_q;
  assign o_ldop       = ldop_q;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed self-checking bench for dcache_req_arbiter with three requesters.
module tb_dcache_req_arbiter;
  import multicore_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 32;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                          i_aclk = 1'b0;
  logic                          i_reset;
  logic [NR-1:0]                 i_req;
  logic [NR-1:0]                 i_req_write;
  logic [NR-1:0][AW-1:0]         i_addr;
  logic [NR-1:0][DATA_SIZE-1:0]  i_store_data;
  t_sop [NR-1:0]                 i_sop;
  t_ldop [NR-1:0]                i_ldop;
  logic [NR-1:0]                 o_gnt;
  logic [NR-1:0]                 o_busy;
  logic [NR-1:0]                 o_done;
  logic [DATA_SIZE-1:0]          o_data;
  logic                          o_req;
  logic                          o_req_write;
  logic [AW-1:0]                 o_addr;
  logic [DATA_SIZE-1:0]          o_store_data;
  t_sop                          o_sop;
  t_ldop                         o_ldop;
  logic                          i_req_ready;
  logic                          i_data_valid;
  logic [DATA_SIZE-1:0]          i_data;

  int n_cmp = 0;
  int n_err = 0;

  dcache_req_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_SIZE (AW)
  ) dut (
    .i_aclk       (i_aclk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_req_write  (i_req_write),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .i_sop        (i_sop),
    .i_ldop       (i_ldop),
    .o_gnt        (o_gnt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_data       (o_data),
    .o_req        (o_req),
    .o_req_write  (o_req_write),
    .o_addr       (o_addr),
    .o_store_data (o_store_data),
    .o_sop        (o_sop),
    .o_ldop       (o_ldop),
    .i_req_ready  (i_req_ready),
    .i_data_valid (i_data_valid),
    .i_data       (i_data)
  );

  always #5 i_aclk = ~i_aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_aclk);
    #1;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    tick;
    tick;
    i_reset = 1'b0;
  endtask

  // One complete transaction for requester idx, entered in an IDLE cycle with
  // requests already driven. Cache accepts immediately, completes next cycle.
  task automatic txn(input string tag, input int unsigned idx, input logic [31:0] rdata);
    logic [2:0]  g;
    logic [31:0] a, sd, sp, lp;
    logic        w;
    g = 3'b001 << idx;
    case (idx)
      0: begin a = 32'h100; w = 1'b0; sd = 32'h11111111; sp = SOP_SB; lp = LDOP_LBU; end
      1: begin a = 32'h300; w = 1'b1; sd = 32'hCAFEF00D; sp = SOP_SH; lp = LDOP_LH;  end
      default: begin a = 32'h400; w = 1'b0; sd = 32'h22222222; sp = SOP_SW; lp = LDOP_LHU; end
    endcase
    check({tag, ":idle_gnt"}, 32'(o_gnt), 32'h0);
    tick;
    i_req_ready = 1'b1;
    #1;
    check({tag, ":iss_req"},   32'(o_req), 32'h1);
    check({tag, ":iss_gnt"},   32'(o_gnt), 32'(g));
    check({tag, ":iss_addr"},  o_addr, a);
    check({tag, ":iss_wr"},    32'(o_req_write), 32'(w));
    check({tag, ":iss_sdata"}, o_store_data, sd);
    check({tag, ":iss_sop"},   32'(o_sop), sp);
    check({tag, ":iss_ldop"},  32'(o_ldop), lp);
    check({tag, ":iss_done"},  32'(o_done), 32'h0);
    tick;
    i_req_ready  = 1'b0;
    i_data_valid = 1'b1;
    i_data       = rdata;
    #1;
    check({tag, ":wt_done"}, 32'(o_done), 32'(g));
    check({tag, ":wt_data"}, o_data, rdata);
    check({tag, ":wt_req"},  32'(o_req), 32'h0);
    check({tag, ":wt_gnt"},  32'(o_gnt), 32'(g));
    check({tag, ":wt_busy"}, 32'(o_busy), 32'(i_req & ~g));
    tick;
    i_data_valid = 1'b0;
    i_data       = '0;
    #1;
    check({tag, ":end_done"}, 32'(o_done), 32'h0);
    check({tag, ":end_data"}, o_data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset      = 1'b1;
    i_req        = '0;
    i_req_write  = 3'b010;
    i_addr[0] = 32'h100;      i_addr[1] = 32'h300;      i_addr[2] = 32'h400;
    i_store_data[0] = 32'h11111111;
    i_store_data[1] = 32'hCAFEF00D;
    i_store_data[2] = 32'h22222222;
    i_sop[0]  = SOP_SB;   i_sop[1]  = SOP_SH;  i_sop[2]  = SOP_SW;
    i_ldop[0] = LDOP_LBU; i_ldop[1] = LDOP_LH; i_ldop[2] = LDOP_LHU;
    i_req_ready  = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;

    // Reset state
    tick;
    tick;
    check("rst_gnt",   32'(o_gnt), 32'h0);
    check("rst_done",  32'(o_done), 32'h0);
    check("rst_req",   32'(o_req), 32'h0);
    check("rst_addr",  o_addr, 32'h0);
    check("rst_sdata", o_store_data, 32'h0);
    check("rst_sop",   32'(o_sop), 32'(SOP_SW));
    check("rst_ldop",  32'(o_ldop), 32'(LDOP_LW));
    check("rst_data",  o_data, 32'h0);
    i_reset = 1'b0;

    // Single load from requester 0
    i_req = 3'b001;
    #1;
    check("load_busy", 32'(o_busy), 32'h1);
    txn("load", 0, 32'hDEADBEEF);
    i_req = '0;

    // Contention between requesters 0 and 1 from reset exit
    do_reset;
    i_req = 3'b011;
    #1;
    txn("cont0", 0, 32'h0000A000);
    txn("cont1", FIXED ? 0 : 1, 32'h0000A001);
    txn("cont2", 0, 32'h0000A002);
    i_req = '0;

    // Cache backpressure on requester 2, with field changes and stray valid
    tick;
    i_req = 3'b100;
    #1;
    check("bp_idle_gnt", 32'(o_gnt), 32'h0);
    for (int unsigned c = 0; c < 5; c++) begin
      tick;
      if (c == 1) begin
        i_addr[2]    = 32'hFFF;
        i_data_valid = 1'b1;
      end else begin
        i_data_valid = 1'b0;
      end
      #1;
      check("bp_req",  32'(o_req), 32'h1);
      check("bp_addr", o_addr, 32'h400);
      check("bp_gnt",  32'(o_gnt), 32'h4);
      check("bp_done", 32'(o_done), 32'h0);
    end
    tick;
    i_req_ready  = 1'b1;
    i_data_valid = 1'b1;
    i_data       = 32'h55;
    #1;
    check("bp_acc_req",  32'(o_req), 32'h1);
    check("bp_acc_done", 32'(o_done), 32'h0);
    tick;
    i_req_ready  = 1'b0;
    i_data_valid = 1'b0;
    #1;
    check("bp_wait_req",  32'(o_req), 32'h0);
    check("bp_wait_done", 32'(o_done), 32'h0);
    check("bp_wait_gnt",  32'(o_gnt), 32'h4);
    tick;
    i_data_valid = 1'b1;
    i_data       = 32'h12345678;
    #1;
    check("bp_done_pulse", 32'(o_done), 32'h4);
    check("bp_done_data",  o_data, 32'h12345678);
    check("bp_done_busy",  32'(o_busy), 32'h0);
    tick;
    i_data_valid = 1'b0;
    i_req        = '0;
    i_addr[2]    = 32'h400;
    #1;
    check("bp_end_gnt", 32'(o_gnt), 32'h0);

    // Requester 1 drops its request while waiting; requester 0 posts meanwhile
    i_req = 3'b010;
    #1;
    check("drop_idle_gnt", 32'(o_gnt), 32'h0);
    tick;
    i_req_ready = 1'b1;
    #1;
    check("drop_iss_gnt", 32'(o_gnt), 32'h2);
    tick;
    i_req_ready = 1'b0;
    i_req       = 3'b001;
    #1;
    check("drop_wait_done", 32'(o_done), 32'h0);
    check("drop_wait_busy", 32'(o_busy), 32'h1);
    tick;
    i_data_valid = 1'b1;
    i_data       = 32'hA5A5A5A5;
    #1;
    check("drop_done",      32'(o_done), 32'h2);
    check("drop_done_data", o_data, 32'hA5A5A5A5);
    check("drop_done_busy", 32'(o_busy), 32'h1);
    tick;
    i_data_valid = 1'b0;
    #1;
    txn("drop_next", 0, 32'h0BADF00D);
    i_req = '0;

    // Reset asserted while waiting; a late completion must be ignored
    tick;
    i_req = 3'b001;
    #1;
    tick;
    i_req_ready = 1'b1;
    #1;
    check("mrst_iss_gnt", 32'(o_gnt), 32'h1);
    tick;
    i_req_ready = 1'b0;
    i_reset     = 1'b1;
    #1;
    check("mrst_wait_gnt", 32'(o_gnt), 32'h1);
    tick;
    i_reset      = 1'b0;
    i_req        = '0;
    i_data_valid = 1'b1;
    i_data       = 32'h00000BAD;
    #1;
    check("mrst_gnt",  32'(o_gnt), 32'h0);
    check("mrst_req",  32'(o_req), 32'h0);
    check("mrst_done", 32'(o_done), 32'h0);
    check("mrst_data", o_data, 32'h0);
    tick;
    i_data_valid = 1'b0;
    #1;
    check("mrst_idle_gnt",  32'(o_gnt), 32'h0);
    check("mrst_idle_done", 32'(o_done), 32'h0);

    // Three-way wrap with the pointer freshly reset
    i_req = 3'b111;
    #1;
    txn("wrap0", 0, 32'h00000010);
    txn("wrap1", FIXED ? 0 : 1, 32'h00000011);
    txn("wrap2", FIXED ? 0 : 2, 32'h00000012);
    txn("wrap3", 0, 32'h00000013);
    i_req = '0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
